cc_mim_microsequencer: RTL and testbench
========================================

CC_MIM_MICROSEQUENCER -- requirements
Module: cc_mim_microsequencer

Interface
REQ-001 Parameter DATAWIDTH_MICROWORD, default 41, width of the microinstruction word.
REQ-002 Parameter DATAWIDTH_ADDRESS, default 11, width of the control-store address.
REQ-003 CC_MIM_Microsequencer_CLOCK_50  in  1  single clock; all state updates on rising edge.
REQ-004 CC_MIM_Microsequencer_RESET_InHigh  in  1  reset, synchronous, active-high.
REQ-005 CC_MIM_Microsequencer_CSAddr_OutBUS  out  11  address driven to the control store.
REQ-006 CC_MIM_Microsequencer_CSData_InBUS  in  41  microword returned combinationally by the control store for CSAddr.
REQ-007 CC_MIM_Microsequencer_IR_InBUS  in  32  current instruction register.
REQ-008 CC_MIM_Microsequencer_Flags_InBUS  in  4  PSR flags {n,z,v,c}.
REQ-009 CC_MIM_Microsequencer_MemACK_InLow  in  1  memory acknowledge, active-low; low = access done this cycle.
REQ-010 CC_MIM_Microsequencer_A_OutBUS, _B_OutBUS, _C_OutBUS  out  6 each  register-file selects from MIR.
REQ-011 CC_MIM_Microsequencer_AMUX, _BMUX, _CMUX  out  1 each  source-select bits from MIR.
REQ-012 CC_MIM_Microsequencer_ALU_OutBUS  out  4  ALU opcode from MIR.
REQ-013 CC_MIM_Microsequencer_RD, _WR  out  1 each  memory read/write request.
REQ-014 CC_MIM_Microsequencer_CWrite  out  1  register-file write strobe, one cycle per completed microinstruction.

Function
REQ-015 Microword fields SHALL be: [40:35]A, [34]AMUX, [33:28]B, [27]BMUX, [26:21]C, [20]CMUX, [19]RD, [18]WR, [17:14]ALU, [13:11]COND, [10:0]JADDR.
REQ-016 Block SHALL hold MIR (41 b) and MPC (11 b, address of the word in MIR).
REQ-017 FSM states SHALL be BOOT, EXEC, WAIT.
REQ-018 BOOT: CSAddr = 0; all strobes (RD, WR, CWrite) low; next edge loads MIR <= CSData, MPC <= 0, goes EXEC.
REQ-019 EXEC with MIR.RD=0 and MIR.WR=0: CWrite = 1; CSAddr = NEXT; edge loads MIR <= CSData, MPC <= NEXT, stays EXEC.
REQ-020 EXEC with RD or WR = 1 and MemACK_InLow = 0: behaves as REQ-019 (zero-wait access).
REQ-021 EXEC with RD or WR = 1 and MemACK_InLow = 1: CWrite = 0; CSAddr = MPC; MIR/MPC held; goes WAIT.
REQ-022 WAIT: RD/WR stay asserted from MIR; CWrite = 0 and CSAddr = MPC until MemACK_InLow = 0; that cycle acts as REQ-019 and returns EXEC.
REQ-023 Field outputs SHALL come straight from MIR in EXEC/WAIT; in BOOT all field outputs = 0.
REQ-024 NEXT by COND: 000 CSAI; 001 n?JADDR:CSAI; 010 z?JADDR:CSAI; 011 v?JADDR:CSAI; 100 c?JADDR:CSAI; 101 IR[13]?JADDR:CSAI; 110 JADDR; 111 DECODE.
REQ-025 CSAI = MPC + 1 modulo 2^11 (2047 -> 0).
REQ-026 DECODE = {1'b1, IR[31:30], IR[24:19], 2'b00}.
REQ-027 Flags and IR SHALL be sampled combinationally in the cycle the branch is taken (EXEC or ack cycle of WAIT); no extra latency.
REQ-028 Simultaneous RD and WR in MIR SHALL be treated as one access (single ack completes both).

Reset
REQ-029 Reset SHALL be synchronous, active-high; while high: state = BOOT, MIR = 0, MPC = 0, all outputs as BOOT (CSAddr = 0, strobes low).
REQ-030 Reset asserted in WAIT SHALL abandon the access: next cycle RD/WR low, BOOT.
REQ-031 Reset SHALL override MemACK and any branch decision in the same cycle.

Structure
REQ-032 Shared package cc_mim_pkg SHALL hold field bit positions, COND code constants, state enumeration and widths 41/11.
REQ-033 Next-address logic SHALL be a combinational sub-module cc_mim_next_addr (inputs MPC, COND, JADDR, flags, IR; output NEXT).
REQ-034 Expected size 150-300 lines RTL including sub-module.

Verification
REQ-035 Reset held 2 cycles then released -> CSAddr = 0 during reset and BOOT, first EXEC has MPC = 0, CWrite = 1 one cycle later.
REQ-036 MPC = 5, COND = 000 -> CSAddr = 6; MPC = 2047, COND = 000 -> CSAddr = 0.
REQ-037 COND = 001, JADDR = 12: flags n=1 -> CSAddr = 12; n=0 at MPC = 8 -> CSAddr = 9.
REQ-038 COND = 111, IR[31:30] = 10, IR[24:19] = 010000 -> CSAddr = 1600; IR[31:30] = 00, IR[24:19] = 010000 -> 1088.
REQ-039 MIR.RD = 1, MemACK_InLow held high 3 cycles then low -> RD high 4 cycles, CSAddr = MPC and CWrite = 0 for 3 cycles, CWrite = 1 and CSAddr = NEXT on ack cycle.
REQ-040 Reset asserted during 2nd WAIT cycle -> RD low and CSAddr = 0 next cycle, FSM in BOOT.

Source files
------------

// File: rtl/cc_mim_pkg.sv
// Shared definitions for the CC MIM microsequencer: widths, microword field positions,
// branch condition codes and sequencer states.
package cc_mim_pkg;

  localparam int unsigned MicrowordWidth = 41;
  localparam int unsigned AddrWidth      = 11;

  localparam int unsigned FieldAHi     = 40;
  localparam int unsigned FieldALo     = 35;
  localparam int unsigned FieldAmux    = 34;
  localparam int unsigned FieldBHi     = 33;
  localparam int unsigned FieldBLo     = 28;
  localparam int unsigned FieldBmux    = 27;
  localparam int unsigned FieldCHi     = 26;
  localparam int unsigned FieldCLo     = 21;
  localparam int unsigned FieldCmux    = 20;
  localparam int unsigned FieldRd      = 19;
  localparam int unsigned FieldWr      = 18;
  localparam int unsigned FieldAluHi   = 17;
  localparam int unsigned FieldAluLo   = 14;
  localparam int unsigned FieldCondHi  = 13;
  localparam int unsigned FieldCondLo  = 11;
  localparam int unsigned FieldJaddrHi = 10;
  localparam int unsigned FieldJaddrLo = 0;

  typedef enum logic [2:0] {
    CondCsai   = 3'b000,
    CondN      = 3'b001,
    CondZ      = 3'b010,
    CondV      = 3'b011,
    CondC      = 3'b100,
    CondIr13   = 3'b101,
    CondJump   = 3'b110,
    CondDecode = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StExec = 2'b01,
    StWait = 2'b10
  } state_e;

endpackage

// File: rtl/cc_mim_next_addr.sv
// Combinational next-microaddress selection: increment, conditional/unconditional jump,
// or opcode decode dispatch from the instruction register.
module cc_mim_next_addr
  import cc_mim_pkg::*;
(
  input  logic [AddrWidth-1:0] mpc_i,
  input  logic [2:0]           cond_i,
  input  logic [AddrWidth-1:0] jaddr_i,
  input  logic [3:0]           flags_i,
  input  logic [31:0]          ir_i,
  output logic [AddrWidth-1:0] next_o
);

  logic [AddrWidth-1:0] csai;
  logic [AddrWidth-1:0] decode;
  logic                 unused_ir;

  // Wraps naturally from the top of the control store back to 0.
  assign csai      = mpc_i + AddrWidth'(1);
  assign decode    = {1'b1, ir_i[31:30], ir_i[24:19], 2'b00};
  assign unused_ir = ^{ir_i[29:25], ir_i[18:14], ir_i[12:0]};

  // Flags are packed {n, z, v, c}.
  always_comb begin
    next_o = csai;
    case (cond_e'(cond_i))
      CondCsai:   next_o = csai;
      CondN:      next_o = flags_i[3] ? jaddr_i : csai;
      CondZ:      next_o = flags_i[2] ? jaddr_i : csai;
      CondV:      next_o = flags_i[1] ? jaddr_i : csai;
      CondC:      next_o = flags_i[0] ? jaddr_i : csai;
      CondIr13:   next_o = ir_i[13]   ? jaddr_i : csai;
      CondJump:   next_o = jaddr_i;
      CondDecode: next_o = decode;
      default:    next_o = csai;
    endcase
  end

endmodule

// File: rtl/cc_mim_microsequencer.sv
// Microprogram sequencer: holds MIR/MPC, drives the control-store address and stalls on
// memory accesses until the active-low acknowledge arrives.
module cc_mim_microsequencer
  import cc_mim_pkg::*;
#(
  parameter int unsigned DATAWIDTH_MICROWORD = MicrowordWidth,
  parameter int unsigned DATAWIDTH_ADDRESS   = AddrWidth
) (
  input  logic                           CC_MIM_Microsequencer_CLOCK_50,
  input  logic                           CC_MIM_Microsequencer_RESET_InHigh,
  output logic [DATAWIDTH_ADDRESS-1:0]   CC_MIM_Microsequencer_CSAddr_OutBUS,
  input  logic [DATAWIDTH_MICROWORD-1:0] CC_MIM_Microsequencer_CSData_InBUS,
  input  logic [31:0]                    CC_MIM_Microsequencer_IR_InBUS,
  input  logic [3:0]                     CC_MIM_Microsequencer_Flags_InBUS,
  input  logic                           CC_MIM_Microsequencer_MemACK_InLow,
  output logic [5:0]                     CC_MIM_Microsequencer_A_OutBUS,
  output logic [5:0]                     CC_MIM_Microsequencer_B_OutBUS,
  output logic [5:0]                     CC_MIM_Microsequencer_C_OutBUS,
  output logic                           CC_MIM_Microsequencer_AMUX,
  output logic                           CC_MIM_Microsequencer_BMUX,
  output logic                           CC_MIM_Microsequencer_CMUX,
  output logic [3:0]                     CC_MIM_Microsequencer_ALU_OutBUS,
  output logic                           CC_MIM_Microsequencer_RD,
  output logic                           CC_MIM_Microsequencer_WR,
  output logic                           CC_MIM_Microsequencer_CWrite
);

  logic                      clk;
  logic                      rst;
  state_e                    state_q, state_d;
  logic [MicrowordWidth-1:0] mir_q, mir_d;
  logic [AddrWidth-1:0]      mpc_q, mpc_d;
  logic [AddrWidth-1:0]      next_addr;
  logic [AddrWidth-1:0]      cs_addr;
  logic                      cwrite;
  logic                      access;
  logic                      ack;
  logic                      boot_view;

  assign clk    = CC_MIM_Microsequencer_CLOCK_50;
  assign rst    = CC_MIM_Microsequencer_RESET_InHigh;
  assign ack    = ~CC_MIM_Microsequencer_MemACK_InLow;
  // RD and WR together are one access completed by a single acknowledge.
  assign access = mir_q[FieldRd] | mir_q[FieldWr];

  cc_mim_next_addr u_next_addr (
    .mpc_i   (mpc_q),
    .cond_i  (mir_q[FieldCondHi:FieldCondLo]),
    .jaddr_i (mir_q[FieldJaddrHi:FieldJaddrLo]),
    .flags_i (CC_MIM_Microsequencer_Flags_InBUS),
    .ir_i    (CC_MIM_Microsequencer_IR_InBUS),
    .next_o  (next_addr)
  );

  always_comb begin
    state_d = state_q;
    mir_d   = mir_q;
    mpc_d   = mpc_q;
    cs_addr = mpc_q;
    cwrite  = 1'b0;
    unique case (state_q)
      StBoot: begin
        cs_addr = '0;
        mir_d   = CC_MIM_Microsequencer_CSData_InBUS;
        mpc_d   = '0;
        state_d = StExec;
      end
      StExec, StWait: begin
        if (!access || ack) begin
          cwrite  = 1'b1;
          cs_addr = next_addr;
          mir_d   = CC_MIM_Microsequencer_CSData_InBUS;
          mpc_d   = next_addr;
          state_d = StExec;
        end else begin
          state_d = StWait;
        end
      end
      default: state_d = StBoot;
    endcase
    // Reset forces the boot view immediately, overriding ack and branch decisions.
    if (rst) begin
      cs_addr = '0;
      cwrite  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      mir_q   <= '0;
      mpc_q   <= '0;
    end else begin
      state_q <= state_d;
      mir_q   <= mir_d;
      mpc_q   <= mpc_d;
    end
  end

  assign boot_view = rst | (state_q == StBoot);

  assign CC_MIM_Microsequencer_CSAddr_OutBUS = cs_addr;
  assign CC_MIM_Microsequencer_CWrite        = cwrite;
  assign CC_MIM_Microsequencer_A_OutBUS      = boot_view ? '0 : mir_q[FieldAHi:FieldALo];
  assign CC_MIM_Microsequencer_B_OutBUS      = boot_view ? '0 : mir_q[FieldBHi:FieldBLo];
  assign CC_MIM_Microsequencer_C_OutBUS      = boot_view ? '0 : mir_q[FieldCHi:FieldCLo];
  assign CC_MIM_Microsequencer_AMUX          = boot_view ? 1'b0 : mir_q[FieldAmux];
  assign CC_MIM_Microsequencer_BMUX          = boot_view ? 1'b0 : mir_q[FieldBmux];
  assign CC_MIM_Microsequencer_CMUX          = boot_view ? 1'b0 : mir_q[FieldCmux];
  assign CC_MIM_Microsequencer_ALU_OutBUS    = boot_view ? '0 : mir_q[FieldAluHi:FieldAluLo];
  assign CC_MIM_Microsequencer_RD            = boot_view ? 1'b0 : mir_q[FieldRd];
  assign CC_MIM_Microsequencer_WR            = boot_view ? 1'b0 : mir_q[FieldWr];

endmodule

// File: tb/tb_cc_mim_microsequencer.sv
// Directed and randomized checks of the microsequencer against a cycle-level reference
// model that tracks only the current microinstruction address and word.
module tb_cc_mim_microsequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack_n;
  logic [3:0]  flags;
  logic [31:0] ir;
  logic [10:0] cs_addr;
  logic [40:0] cs_data;
  logic [5:0]  a_bus, b_bus, c_bus;
  logic        amux, bmux, cmux;
  logic [3:0]  alu;
  logic        rd, wr, cwrite;

  logic [40:0] cs_mem [2048];
  assign cs_data = cs_mem[cs_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  bit          m_boot = 1'b1;
  int          m_pc   = 0;
  logic [40:0] m_word = '0;

  always #5 clk = ~clk;

  cc_mim_microsequencer dut (
    .CC_MIM_Microsequencer_CLOCK_50     (clk),
    .CC_MIM_Microsequencer_RESET_InHigh (rst),
    .CC_MIM_Microsequencer_CSAddr_OutBUS(cs_addr),
    .CC_MIM_Microsequencer_CSData_InBUS (cs_data),
    .CC_MIM_Microsequencer_IR_InBUS     (ir),
    .CC_MIM_Microsequencer_Flags_InBUS  (flags),
    .CC_MIM_Microsequencer_MemACK_InLow (ack_n),
    .CC_MIM_Microsequencer_A_OutBUS     (a_bus),
    .CC_MIM_Microsequencer_B_OutBUS     (b_bus),
    .CC_MIM_Microsequencer_C_OutBUS     (c_bus),
    .CC_MIM_Microsequencer_AMUX         (amux),
    .CC_MIM_Microsequencer_BMUX         (bmux),
    .CC_MIM_Microsequencer_CMUX         (cmux),
    .CC_MIM_Microsequencer_ALU_OutBUS   (alu),
    .CC_MIM_Microsequencer_RD           (rd),
    .CC_MIM_Microsequencer_WR           (wr),
    .CC_MIM_Microsequencer_CWrite       (cwrite)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mk(input bit r, input bit w, input logic [2:0] cond,
                                     input logic [10:0] j);
    logic [40:0] word;
    word[40:20] = 21'($urandom);
    word[17:14] = 4'($urandom);
    word[19]    = r;
    word[18]    = w;
    word[13:11] = cond;
    word[10:0]  = j;
    return word;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [1:0] hi, input logic [5:0] mid);
    logic [31:0] v;
    v        = $urandom;
    v[31:30] = hi;
    v[24:19] = mid;
    return v;
  endfunction

  // Next address straight from the branch rules, in plain integer arithmetic.
  function automatic int ref_next(input int pc, input logic [40:0] w, input logic [3:0] f,
                                  input logic [31:0] irv);
    int  csai;
    int  j;
    bit  take;
    csai = (pc + 1) % 2048;
    j    = int'(w[10:0]);
    take = 1'b0;
    case (int'(w[13:11]))
      0: return csai;
      1: take = f[3];
      2: take = f[2];
      3: take = f[1];
      4: take = f[0];
      5: take = irv[13];
      6: return j;
      default: return 1024 + int'(irv[31:30]) * 256 + int'(irv[24:19]) * 4;
    endcase
    return take ? j : csai;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit r, input bit a_n, input logic [3:0] f, input logic [31:0] irv,
                      input string tag, input int want_addr, input int want_cw);
    int          e_addr;
    bit          e_cw;
    logic [1:0]  e_rdwr;
    logic [24:0] e_fields;
    bit          done;
    int          nxt;
    rst   = r;
    ack_n = a_n;
    flags = f;
    ir    = irv;
    @(negedge clk);
    done = 1'b0;
    nxt  = 0;
    if (r || m_boot) begin
      e_addr   = 0;
      e_cw     = 1'b0;
      e_rdwr   = 2'b00;
      e_fields = '0;
    end else begin
      done     = !(m_word[19] || m_word[18]) || !a_n;
      nxt      = ref_next(m_pc, m_word, f, irv);
      e_addr   = done ? nxt : m_pc;
      e_cw     = done;
      e_rdwr   = m_word[19:18];
      e_fields = {m_word[40:35], m_word[34], m_word[33:28], m_word[27], m_word[26:21],
                  m_word[20], m_word[17:14]};
    end
    check({tag, ".csaddr"}, 64'(cs_addr), 64'(e_addr));
    check({tag, ".cwrite"}, 64'(cwrite), 64'(e_cw));
    check({tag, ".rdwr"}, 64'({rd, wr}), 64'(e_rdwr));
    check({tag, ".fields"}, 64'({a_bus, amux, b_bus, bmux, c_bus, cmux, alu}), 64'(e_fields));
    if (want_addr >= 0) check({tag, ".spec_addr"}, 64'(cs_addr), 64'(want_addr));
    if (want_cw >= 0) check({tag, ".spec_cw"}, 64'(cwrite), 64'(want_cw));
    @(posedge clk);
    if (r) begin
      m_boot = 1'b1;
      m_pc   = 0;
      m_word = '0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_pc   = 0;
      m_word = cs_mem[0];
    end else if (done) begin
      m_pc   = nxt;
      m_word = cs_mem[nxt];
    end
    #1;
  endtask

  task automatic fill_idle();
    for (int i = 0; i < 2048; i++) cs_mem[i] = mk(1'b0, 1'b0, 3'b110, 11'd0);
  endtask

  initial begin
    rst   = 1'b1;
    ack_n = 1'b1;
    flags = 4'h0;
    ir    = '0;

    // Reset hold, boot, increment and wrap at the top of the store.
    fill_idle();
    cs_mem[0]    = mk(1'b0, 1'b0, 3'b110, 11'd5);
    cs_mem[5]    = mk(1'b0, 1'b0, 3'b000, 11'd77);
    cs_mem[6]    = mk(1'b0, 1'b0, 3'b110, 11'd2047);
    cs_mem[2047] = mk(1'b0, 1'b0, 3'b000, 11'd3);
    step(1, 1, 4'h0, '0, "rst0", 0, 0);
    step(1, 1, 4'h0, '0, "rst1", 0, 0);
    step(0, 1, 4'h0, '0, "boot", 0, 0);
    step(0, 1, 4'h0, '0, "exec0", 5, 1);
    step(0, 1, 4'h0, '0, "csai5", 6, 1);
    step(0, 1, 4'h0, '0, "jmp2047", 2047, 1);
    step(0, 1, 4'h0, '0, "wrap", 0, 1);

    // Flag branches, decode dispatch, memory wait and reset during wait.
    fill_idle();
    cs_mem[0]    = mk(1'b0, 1'b0, 3'b001, 11'd12);
    cs_mem[12]   = mk(1'b0, 1'b0, 3'b110, 11'd8);
    cs_mem[8]    = mk(1'b0, 1'b0, 3'b001, 11'd12);
    cs_mem[9]    = mk(1'b0, 1'b0, 3'b111, 11'd0);
    cs_mem[1600] = mk(1'b0, 1'b0, 3'b111, 11'd0);
    cs_mem[1088] = mk(1'b1, 1'b0, 3'b000, 11'd0);
    cs_mem[1089] = mk(1'b1, 1'b1, 3'b110, 11'd100);
    step(1, 1, 4'h0, '0, "rst", 0, 0);
    step(0, 1, 4'h0, '0, "boot", 0, 0);
    step(0, 1, 4'b1000, '0, "n_taken", 12, 1);
    step(0, 1, 4'h0, '0, "jmp8", 8, 1);
    step(0, 1, 4'b0111, '0, "n_not", 9, 1);
    step(0, 1, 4'h0, mk_ir(2'b10, 6'b010000), "dec1600", 1600, 1);
    step(0, 1, 4'h0, mk_ir(2'b00, 6'b010000), "dec1088", 1088, 1);
    step(0, 1, 4'h0, '0, "rd_wait0", 1088, 0);
    step(0, 1, 4'h0, '0, "rd_wait1", 1088, 0);
    step(0, 1, 4'h0, '0, "rd_wait2", 1088, 0);
    step(0, 0, 4'h0, '0, "rd_ack", 1089, 1);
    step(0, 1, 4'h0, '0, "rw_wait0", 1089, 0);
    step(0, 1, 4'h0, '0, "rw_wait1", 1089, 0);
    step(1, 0, 4'hf, '0, "rst_in_wait", 0, 0);
    step(0, 1, 4'h0, '0, "boot_after", 0, 0);
    check("boot_after.rd", 64'(rd), 64'(0));
    step(0, 1, 4'b1000, '0, "rerun", 12, 1);

    // Random control store and random stimulus.
    for (int i = 0; i < 2048; i++) begin
      cs_mem[i] = mk(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     3'($urandom), 11'($urandom));
    end
    step(1, 1, 4'h0, '0, "rnd_rst", 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) >= 4), 4'($urandom),
           $urandom, "rnd", -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
